prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Writer side of the CPU's 8-bit instruction memory; the CPU only reads it.
- Accepts a framed byte stream on a valid/ready input and writes the payload into instruction memory starting at address 0.
- Holds the CPU in reset while loading and releases it when a frame completes cleanly.
- Sits between a host byte source (UART receiver or bench) and the instruction-memory write port plus the CPU reset input.

Parameters:
- ADDR_W, 8, instruction-memory address width; maximum payload is 2^ADDR_W bytes.
- TIMEOUT_CYCLES, 1024, idle cycles allowed between accepted bytes inside a frame before it is aborted.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input byte valid.
- in_data  in  8  input byte.
- in_ready  out  1  loader can accept a byte.
- mem_we  out  1  instruction-memory write strobe, one cycle per payload byte.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  8  write data.
- cpu_hold  out  1  drives the CPU reset input; 1 holds the CPU.
- done  out  1  last frame loaded successfully (level).
- error  out  1  last frame aborted (level).
- bytes_loaded  out  ADDR_W+1  payload bytes written in the current or last frame.

Behaviour:
- A byte is accepted on any rising clk edge where in_valid && in_ready.
- in_ready is 0 during reset and 1 in every state otherwise. No back-pressure.
- Reset values:
  - state=IDLE, cpu_hold=1, done=0, error=0, mem_we=0, mem_addr=0, mem_wdata=0, bytes_loaded=0.
  - Internal counters and checksum are 0.
- Frame format: SYNC_BYTE, LEN, LEN payload bytes, then a CHK byte only when the optional feature is enabled.
  - LEN=0 encodes 2^ADDR_W bytes.
  - For ADDR_W<8, LEN values above 2^ADDR_W go to ERR on acceptance.
- States:
  - IDLE: discards bytes other than SYNC_BYTE; SYNC_BYTE -> LEN.
  - LEN: latches the length, clears the byte counter and checksum -> DATA.
  - DATA: on each accepted byte, registers mem_we=1, mem_addr=counter, mem_wdata=byte, valid the following cycle (1-cycle write latency).
    - Increments the counter and adds the byte to the 8-bit checksum (mod 256).
    - After the LEN-th byte -> CHK if enabled, else DONE.
  - CHK: see Optional Feature.
  - DONE: done=1, cpu_hold=0. Other bytes are ignored.
  - ERR: error=1, cpu_hold=1. Other bytes are ignored.
- Restart: SYNC_BYTE accepted in DONE or ERR -> LEN.
  - On the next cycle: done=0, error=0, cpu_hold=1, bytes_loaded=0.
  - SYNC_BYTE inside DATA is ordinary payload.
- cpu_hold:
  - Registered.
  - Deasserts on the cycle after the final payload or CHK byte is accepted, which is the same cycle the last mem_we is visible.
  - Is 1 in every state except DONE.
- mem_we is high for exactly one cycle per payload byte and is never high outside DATA-accepted bytes.
- bytes_loaded is updated in the same cycle as mem_we.
- Timeout:
  - In LEN, DATA and CHK, a counter increments on each cycle with no accepted byte and clears on acceptance.
  - When it reaches TIMEOUT_CYCLES -> ERR.
  - Memory already written is left as-is.
  - In IDLE, DONE and ERR the counter is held at 0.
- Address wraps are impossible: the counter stops at LEN.
- Asserting reset mid-frame aborts immediately to reset values.
  - Partial memory contents are undefined to the CPU.
  - The CPU stays held.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- With it:
  - After the payload the FSM enters CHK.
  - The accepted CHK byte is added to the running sum.
  - A sum of 8'h00 -> DONE; anything else -> ERR.
- Without it:
  - The CHK state and checksum logic are absent.
  - The last payload byte goes directly to DONE.
  - Frames carry no CHK byte.

Decomposition:
- Package prog_loader_pkg holds:
  - the state enum (IDLE, LEN, DATA, CHK, DONE, ERR);
  - the default SYNC_BYTE constant;
  - the frame-format constants.
- No sub-module: the timeout counter and checksum accumulator stay inline.
- The bench reuses the package for frame building.

Test Plan:
- Clean load, feature off:
  - Stimulus: A5, 03, 20, 41, E0.
  - Response: mem_we pulses at addr 0/1/2 with data 20/41/E0; bytes_loaded=3; done=1; cpu_hold falls the cycle after E0 is accepted.
- Checksum pass/fail, feature on:
  - A5, 02, 10, 20, D0 -> done=1.
  - Same frame with CHK=D1 -> error=1, cpu_hold stays 1, memory shows 10/20 at addr 0/1.
- Leading garbage plus sync byte as payload: 00, FF, A5, 01, A5 -> garbage ignored; one write, addr 0 data A5; done=1.
- Timeout: A5, 04, 11, then in_valid=0 for TIMEOUT_CYCLES cycles -> error=1 exactly at TIMEOUT_CYCLES idle cycles; a following frame A5, 01, 07 -> done=1, error=0.
- Full-size frame: LEN=00 with 256 bytes (value = index) -> 256 writes at addr 0..255; bytes_loaded=256; done=1.
- Reset mid-frame: assert reset after the second payload byte -> all outputs return to reset values asynchronously; cpu_hold=1; no further mem_we.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared types and frame-format constants for the
// instruction-memory loader. Shared with the bench for frame building.
// Optional checksum trailer enabled by PROG_LOADER_CHECKSUM_EN.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CHK  = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

  // Default frame start marker
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // Frame layout: SYNC, LEN, payload, optional CHK
  localparam int FRAME_HDR_BYTES = 2;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam int FRAME_CHK_BYTES = 1;
`else
  localparam int FRAME_CHK_BYTES = 0;
`endif

  // LEN byte that encodes a payload of n bytes (n == 2^ADDR_W maps to 0)
  function automatic logic [7:0] len_code(input int n);
    logic [31:0] v;
    v = n;
    return v[7:0];
  endfunction

  // Trailer byte that makes the 8-bit sum of payload + trailer zero
  function automatic logic [7:0] chk_trailer(input logic [7:0] payload_sum);
    return 8'h00 - payload_sum;
  endfunction

endpackage

// File: rtl/prog_loader.sv
// prog_loader: writes a framed byte stream into the CPU instruction memory
// from address 0, holding the CPU in reset until a frame lands cleanly.
// Frame: SYNC, LEN (0 => 2^ADDR_W), LEN payload bytes, [CHK].
// Define PROG_LOADER_CHECKSUM_EN to require a CHK byte making the sum zero.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int         ADDR_W         = 8,
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   bytes_loaded
);

  localparam int CW     = ADDR_W + 1;
  localparam int MAXLEN = 1 << ADDR_W;
  localparam int TW     = $clog2(TIMEOUT_CYCLES + 1);

  state_e              state_q, state_d;
  logic [CW-1:0]       len_q, len_d;
  logic [CW-1:0]       bytes_loaded_q, bytes_loaded_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_wdata_q, mem_wdata_d;
  logic                cpu_hold_q, cpu_hold_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]          chk_q, chk_d;
  logic [7:0]          chk_sum;
`endif

  logic                accept;
  logic [8:0]          len_ext;
  logic [CW-1:0]       bl_inc;
  logic                in_frame;

  // No back-pressure: ready whenever out of reset
  assign in_ready = ~reset;
  assign accept   = in_valid & in_ready;
  assign len_ext  = (in_data == 8'h00) ? 9'(MAXLEN) : {1'b0, in_data};
  assign bl_inc   = bytes_loaded_q + CW'(1);
  assign in_frame = (state_q == ST_LEN) || (state_q == ST_DATA) ||
                    (state_q == ST_CHK);
`ifdef PROG_LOADER_CHECKSUM_EN
  assign chk_sum  = chk_q + in_data;
`endif

  // Next-state and registered-output logic for the frame parser
  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    bytes_loaded_d = bytes_loaded_q;
    tmo_d          = '0;
    mem_we_d       = 1'b0;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    cpu_hold_d     = cpu_hold_q;
    done_d         = done_q;
    error_d        = error_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    chk_d          = chk_q;
`endif

    // Inter-byte watchdog, only live while a frame is open
    if (in_frame && !accept) tmo_d = tmo_q + TW'(1);

    case (state_q)
      ST_IDLE: begin
        if (accept && in_data == SYNC_BYTE) state_d = ST_LEN;
      end

      ST_LEN: begin
        if (accept) begin
          bytes_loaded_d = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
          chk_d          = 8'h00;
`endif
          if (len_ext > 9'(MAXLEN)) begin
            state_d    = ST_ERR;
            error_d    = 1'b1;
            cpu_hold_d = 1'b1;
          end else begin
            len_d   = len_ext[CW-1:0];
            state_d = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        // SYNC_BYTE here is just payload
        if (accept) begin
          mem_we_d       = 1'b1;
          mem_addr_d     = bytes_loaded_q[ADDR_W-1:0];
          mem_wdata_d    = in_data;
          bytes_loaded_d = bl_inc;
`ifdef PROG_LOADER_CHECKSUM_EN
          chk_d          = chk_sum;
          if (bl_inc == len_q) state_d = ST_CHK;
`else
          if (bl_inc == len_q) begin
            state_d    = ST_DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end
`endif
        end
      end

`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (accept) begin
          chk_d = chk_sum;
          if (chk_sum == 8'h00) begin
            state_d    = ST_DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            state_d    = ST_ERR;
            error_d    = 1'b1;
            cpu_hold_d = 1'b1;
          end
        end
      end
`endif

      ST_DONE, ST_ERR: begin
        // Only a fresh SYNC restarts; everything else is dropped
        if (accept && in_data == SYNC_BYTE) begin
          state_d        = ST_LEN;
          done_d         = 1'b0;
          error_d        = 1'b0;
          cpu_hold_d     = 1'b1;
          bytes_loaded_d = '0;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        cpu_hold_d = 1'b1;
      end
    endcase

    // Abort a stalled frame; memory already written stays as-is
    if (in_frame && !accept && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d    = ST_ERR;
      error_d    = 1'b1;
      cpu_hold_d = 1'b1;
      tmo_d      = '0;
    end
  end

  // State and output registers; reset aborts any frame and holds the CPU
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      len_q          <= '0;
      bytes_loaded_q <= '0;
      tmo_q          <= '0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      cpu_hold_q     <= 1'b1;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      chk_q          <= 8'h00;
`endif
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      bytes_loaded_q <= bytes_loaded_d;
      tmo_q          <= tmo_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      cpu_hold_q     <= cpu_hold_d;
      done_q         <= done_d;
      error_q        <= error_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      chk_q          <= chk_d;
`endif
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign cpu_hold     = cpu_hold_q;
  assign done         = done_q;
  assign error        = error_q;
  assign bytes_loaded = bytes_loaded_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed frames against prog_loader; every memory write
// is checked against a queue of expected (addr, data, bytes_loaded).
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 1024;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   bytes_loaded;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic [8:0] bl;
  } wr_t;

  wr_t        exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] payload[256];

  prog_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TIMEOUT), .SYNC_BYTE(SYNC_BYTE_DEF)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .done(done),
    .error(error), .bytes_loaded(bytes_loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: each write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {mem_addr, mem_wdata}, 32'hFFFF_FFFF);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(w.addr));
        check("wr_data", 32'(mem_wdata), 32'(w.data));
        check("wr_bytes_loaded", 32'(bytes_loaded), 32'(w.bl));
      end
    end
  end

  task automatic expect_wr(input int a, input logic [7:0] d);
    wr_t w;
    logic [31:0] av;
    av = a;
    w.addr = av[7:0];
    w.data = d;
    w.bl   = 9'(a + 1);
    exp_q.push_back(w);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Whole frame from payload[0..n-1]; trailer appended when checksum is built in
  task automatic load_frame(input int n);
    logic [7:0] sum;
    sum = 8'h00;
    send_byte(SYNC_BYTE_DEF);
    send_byte(len_code(n));
    for (int i = 0; i < n; i++) begin
      expect_wr(i, payload[i]);
      sum = sum + payload[i];
      send_byte(payload[i]);
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(8'h00 - sum);
`else
    if (sum == 8'hxx) sum = 8'h00;
`endif
  endtask

  task automatic drain(input string tag);
    @(negedge clk);
    #1 check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_bytes_loaded", 32'(bytes_loaded), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 check("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Garbage in IDLE, then a SYNC byte used as payload
    send_byte(8'h00);
    send_byte(8'hFF);
    check("garbage_hold", 32'(cpu_hold), 32'd1);
    payload[0] = 8'hA5;
    load_frame(1);
    check("garbage_done", 32'(done), 32'd1);
    check("garbage_bl", 32'(bytes_loaded), 32'd1);
    drain("garbage_drain");

    // Clean 3-byte load with cpu_hold timing around the last byte
    send_byte(SYNC_BYTE_DEF);
    check("restart_done_clr", 32'(done), 32'd0);
    check("restart_bl_clr", 32'(bytes_loaded), 32'd0);
    send_byte(8'h03);
    expect_wr(0, 8'h20); send_byte(8'h20);
    expect_wr(1, 8'h41); send_byte(8'h41);
    check("clean_hold_before_last", 32'(cpu_hold), 32'd1);
    expect_wr(2, 8'hE0); send_byte(8'hE0);
`ifdef PROG_LOADER_CHECKSUM_EN
    check("clean_hold_before_chk", 32'(cpu_hold), 32'd1);
    send_byte(8'h00 - 8'h20 - 8'h41 - 8'hE0);
`else
    check("clean_last_we", 32'(mem_we), 32'd1);
`endif
    check("clean_hold_released", 32'(cpu_hold), 32'd0);
    check("clean_done", 32'(done), 32'd1);
    check("clean_error", 32'(error), 32'd0);
    check("clean_bl", 32'(bytes_loaded), 32'd3);
    drain("clean_drain");

`ifdef PROG_LOADER_CHECKSUM_EN
    // Checksum pass then fail
    send_byte(SYNC_BYTE_DEF); send_byte(8'h02);
    expect_wr(0, 8'h10); send_byte(8'h10);
    expect_wr(1, 8'h20); send_byte(8'h20);
    send_byte(8'hD0);
    check("chk_pass_done", 32'(done), 32'd1);
    check("chk_pass_hold", 32'(cpu_hold), 32'd0);
    send_byte(SYNC_BYTE_DEF); send_byte(8'h02);
    expect_wr(0, 8'h10); send_byte(8'h10);
    expect_wr(1, 8'h20); send_byte(8'h20);
    send_byte(8'hD1);
    check("chk_fail_error", 32'(error), 32'd1);
    check("chk_fail_done", 32'(done), 32'd0);
    check("chk_fail_hold", 32'(cpu_hold), 32'd1);
    drain("chk_drain");
`endif

    // Timeout: stall after one payload byte of four
    send_byte(SYNC_BYTE_DEF); send_byte(8'h04);
    expect_wr(0, 8'h11); send_byte(8'h11);
    repeat (TIMEOUT - 1) @(posedge clk);
    #1 check("tmo_not_yet", 32'(error), 32'd0);
    check("tmo_hold_pre", 32'(cpu_hold), 32'd1);
    @(posedge clk);
    #1 check("tmo_error", 32'(error), 32'd1);
    check("tmo_hold", 32'(cpu_hold), 32'd1);
    check("tmo_bl", 32'(bytes_loaded), 32'd1);
    payload[0] = 8'h07;
    load_frame(1);
    check("tmo_recover_done", 32'(done), 32'd1);
    check("tmo_recover_error", 32'(error), 32'd0);
    drain("tmo_drain");

    // Full-size frame: LEN=0 means 256 bytes
    for (int i = 0; i < 256; i++) payload[i] = 8'(i);
    load_frame(256);
    check("full_done", 32'(done), 32'd1);
    check("full_bl", 32'(bytes_loaded), 32'd256);
    check("full_hold", 32'(cpu_hold), 32'd0);
    drain("full_drain");

    // Reset in the middle of a frame
    send_byte(SYNC_BYTE_DEF); send_byte(8'h03);
    expect_wr(0, 8'h01); send_byte(8'h01);
    expect_wr(1, 8'h02); send_byte(8'h02);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("midrst_we", 32'(mem_we), 32'd0);
    check("midrst_hold", 32'(cpu_hold), 32'd1);
    check("midrst_bl", 32'(bytes_loaded), 32'd0);
    check("midrst_addr", 32'(mem_addr), 32'd0);
    check("midrst_wdata", 32'(mem_wdata), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    in_valid = 1'b1;
    in_data  = 8'h03;
    repeat (3) @(posedge clk);
    #1 check("midrst_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    send_byte(8'h03);
    check("postrst_idle_hold", 32'(cpu_hold), 32'd1);
    check("postrst_idle_bl", 32'(bytes_loaded), 32'd0);
    payload[0] = 8'h5A;
    payload[1] = 8'hC3;
    load_frame(2);
    check("postrst_done", 32'(done), 32'd1);
    check("postrst_bl", 32'(bytes_loaded), 32'd2);
    drain("final_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
